// File: rtl/pipeline_pkg.sv
// Shared types and helpers for the core pipeline stages.
package pipeline_pkg;

    typedef struct packed {
        logic flush;
        logic freeze;
        logic soft_reset;
    } stage_ctrl_t;

    // Pointer width that never collapses to zero for single-entry buffers.
    function automatic int unsigned clog2_safe(input int unsigned n);
        if (n <= 1) return 1;
        return $unsigned($clog2(n));
    endfunction

endpackage

// File: rtl/ring_ptr_ctrl.sv
// Circular-buffer bookkeeping: read/write pointers with arbitrary-DEPTH wrap and an explicit count.
module ring_ptr_ctrl
    import pipeline_pkg::*;
#(
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned PTR_W = clog2_safe(DEPTH),
    localparam int unsigned OCC_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic             pop_i,
    output logic [PTR_W-1:0] wr_ptr_o,
    output logic [PTR_W-1:0] rd_ptr_o,
    output logic [OCC_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] count_q, count_d;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop_i)  rd_ptr_d = ptr_inc(rd_ptr_q);
            case ({push_i, pop_i})
                2'b10:   count_d = count_q + OCC_W'(1);
                2'b01:   count_d = count_q - OCC_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign wr_ptr_o = wr_ptr_q;
    assign rd_ptr_o = rd_ptr_q;
    assign count_o  = count_q;
    assign full_o   = (count_q == OCC_W'(DEPTH));
    assign empty_o  = (count_q == '0);

endmodule

// File: rtl/elastic_pipeline_stage.sv
// Multi-entry valid/ready pipeline register with flush, soft reset, global freeze and stall statistics.
module elastic_pipeline_stage
    import pipeline_pkg::*;
#(
    parameter  int unsigned WIDTH = 97,
    parameter  int unsigned DEPTH = 2,
    parameter  int unsigned CNT_W = 16,
    localparam int unsigned PTR_W = clog2_safe(DEPTH),
    localparam int unsigned OCC_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             soft_reset_i,
    input  logic             freeze_i,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o,
    output logic [OCC_W-1:0] occupancy_o,
    output logic [CNT_W-1:0] stall_count_o,
    output logic [WIDTH-1:0] flat_o
);

    stage_ctrl_t      ctrl;
    logic             clr_all;
    logic             push, pop;
    logic             full, empty;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [CNT_W-1:0] stall_q, stall_d;

    assign ctrl    = '{flush: flush_i, freeze: freeze_i, soft_reset: soft_reset_i};
    assign clr_all = rst_i | ctrl.soft_reset;

    // Readiness depends only on own state and freeze, never on the opposite side.
    assign in_ready_o  = !full  && !ctrl.freeze;
    assign out_valid_o = !empty && !ctrl.freeze;
    assign push        = in_valid_i  && in_ready_o;
    assign pop         = out_valid_o && out_ready_i;

    ring_ptr_ctrl #(.DEPTH(DEPTH)) u_ptr (
        .clk_i    (clk_i),
        .rst_i    (clr_all),
        .clear_i  (ctrl.flush),
        .push_i   (push),
        .pop_i    (pop),
        .wr_ptr_o (wr_ptr),
        .rd_ptr_o (rd_ptr),
        .count_o  (occupancy_o),
        .full_o   (full),
        .empty_o  (empty)
    );

    always_ff @(posedge clk_i) begin
        if (clr_all) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (!ctrl.flush && push) begin
            mem_q[wr_ptr] <= in_data_i;
        end
    end

    // Saturating stall counter; a flush cycle commits nothing, freeze already masks out_valid_o.
    always_comb begin
        stall_d = stall_q;
        if (!ctrl.flush && out_valid_o && !out_ready_i && (stall_q != '1))
            stall_d = stall_q + CNT_W'(1);
    end

    always_ff @(posedge clk_i) begin
        if (clr_all) stall_q <= '0;
        else         stall_q <= stall_d;
    end

    assign out_data_o    = empty ? '0 : mem_q[rd_ptr];
    assign flat_o        = out_data_o;
    assign stall_count_o = stall_q;

endmodule

// File: tb/tb_elastic_pipeline_stage.sv
// Directed bench: DEPTH=2/CNT_W=4 instance (a_*) and DEPTH=3/CNT_W=16 instance (b_*).
module tb_elastic_pipeline_stage;

    localparam int unsigned W = 97;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic         a_rst, a_srst, a_frz, a_fl, a_iv, a_ir, a_ov, a_or;
    logic [W-1:0] a_din, a_dout, a_flat;
    logic [1:0]   a_occ;
    logic [3:0]   a_stall;

    logic         b_rst, b_srst, b_frz, b_fl, b_iv, b_ir, b_ov, b_or;
    logic [W-1:0] b_din, b_dout, b_flat;
    logic [1:0]   b_occ;
    logic [15:0]  b_stall;

    elastic_pipeline_stage #(.WIDTH(W), .DEPTH(2), .CNT_W(4)) u_a (
        .clk_i(clk), .rst_i(a_rst), .soft_reset_i(a_srst), .freeze_i(a_frz), .flush_i(a_fl),
        .in_valid_i(a_iv), .in_ready_o(a_ir), .in_data_i(a_din),
        .out_valid_o(a_ov), .out_ready_i(a_or), .out_data_o(a_dout),
        .occupancy_o(a_occ), .stall_count_o(a_stall), .flat_o(a_flat)
    );

    elastic_pipeline_stage #(.WIDTH(W), .DEPTH(3), .CNT_W(16)) u_b (
        .clk_i(clk), .rst_i(b_rst), .soft_reset_i(b_srst), .freeze_i(b_frz), .flush_i(b_fl),
        .in_valid_i(b_iv), .in_ready_o(b_ir), .in_data_i(b_din),
        .out_valid_o(b_ov), .out_ready_i(b_or), .out_data_o(b_dout),
        .occupancy_o(b_occ), .stall_count_o(b_stall), .flat_o(b_flat)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        {a_rst, a_srst, a_frz, a_fl, a_iv, a_or} = 6'b100000;
        {b_rst, b_srst, b_frz, b_fl, b_iv, b_or} = 6'b100000;
        a_din = '0;
        b_din = '0;
        tick();
        tick();
        a_rst = 1'b0;
        b_rst = 1'b0;
        #1;

        // Reset state
        chk("a_rst_occ",   128'(a_occ),   128'd0);
        chk("a_rst_ov",    128'(a_ov),    128'd0);
        chk("a_rst_ir",    128'(a_ir),    128'd1);
        chk("a_rst_dout",  128'(a_dout),  128'd0);
        chk("a_rst_stall", 128'(a_stall), 128'd0);
        chk("b_rst_flat",  128'(b_flat),  128'd0);

        // Two back-to-back pushes under backpressure
        a_iv = 1'b1; a_din = W'(32'hA);
        tick();
        a_din = W'(32'hB);
        chk("t1_occ1",   128'(a_occ),   128'd1);
        chk("t1_dout1",  128'(a_dout),  128'hA);
        chk("t1_stall0", 128'(a_stall), 128'd0);
        tick();
        a_iv = 1'b0;
        chk("t1_occ2",   128'(a_occ),   128'd2);
        chk("t1_ir",     128'(a_ir),    128'd0);
        chk("t1_dout2",  128'(a_dout),  128'hA);
        chk("t1_stall1", 128'(a_stall), 128'd1);
        tick();
        chk("t1_stall2", 128'(a_stall), 128'd2);

        // Flush while full with a push offered
        a_iv = 1'b1; a_din = W'(32'hC); a_fl = 1'b1;
        tick();
        a_iv = 1'b0; a_fl = 1'b0;
        chk("t3_occ",   128'(a_occ),   128'd0);
        chk("t3_ov",    128'(a_ov),    128'd0);
        chk("t3_dout",  128'(a_dout),  128'd0);
        chk("t3_stall", 128'(a_stall), 128'd2);
        a_iv = 1'b1; a_din = W'(32'hD);
        tick();
        a_iv = 1'b0;
        chk("t3_next_head", 128'(a_dout), 128'hD);
        chk("t3_next_occ",  128'(a_occ),  128'd1);

        // Freeze for 5 cycles with valid/ready asserted
        a_frz = 1'b1; a_or = 1'b1; a_iv = 1'b1; a_din = W'(32'hF);
        #1;
        chk("t4_ir_frz", 128'(a_ir), 128'd0);
        chk("t4_ov_frz", 128'(a_ov), 128'd0);
        for (int i = 0; i < 5; i++) tick();
        chk("t4_occ",   128'(a_occ),   128'd1);
        chk("t4_stall", 128'(a_stall), 128'd2);
        chk("t4_flat",  128'(a_flat),  128'hD);
        chk("t4_dout",  128'(a_dout),  128'hD);
        a_frz = 1'b0; a_or = 1'b0; a_iv = 1'b0;
        #1;
        chk("t4_ov_unfrz", 128'(a_ov), 128'd1);

        // Stall counter saturation at 15
        for (int i = 0; i < 12; i++) tick();
        chk("t5_stall14", 128'(a_stall), 128'd14);
        for (int i = 0; i < 8; i++) tick();
        chk("t5_stall15", 128'(a_stall), 128'd15);
        a_or = 1'b1;
        tick();
        a_or = 1'b0;
        chk("t5_pop_occ",   128'(a_occ),   128'd0);
        chk("t5_pop_dout",  128'(a_dout),  128'd0);
        chk("t5_pop_stall", 128'(a_stall), 128'd15);

        // DEPTH=3 streaming across pointer wrap
        b_or = 1'b1; b_iv = 1'b1; b_din = W'(32'h100);
        #1;
        chk("t2_no_bypass", 128'(b_ov), 128'd0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("t2_data%0d", i), 128'(b_dout), 128'(32'h100 + i));
            chk($sformatf("t2_occ%0d", i),  128'(b_occ),  128'd1);
            b_din = W'(32'h101 + i);
        end
        b_iv = 1'b0;
        tick();
        chk("t2_drain_occ", 128'(b_occ), 128'd0);
        chk("t2_drain_ov",  128'(b_ov),  128'd0);

        // Hard reset mid-stream with a push offered
        b_or = 1'b0; b_iv = 1'b1; b_din = W'(32'h11);
        tick();
        b_din = W'(32'h12);
        tick();
        chk("t6_pre_occ",   128'(b_occ),   128'd2);
        chk("t6_pre_stall", 128'(b_stall), 128'd1);
        b_din = W'(32'h13); b_rst = 1'b1;
        tick();
        b_rst = 1'b0; b_iv = 1'b0;
        chk("t6_rst_occ",   128'(b_occ),   128'd0);
        chk("t6_rst_ov",    128'(b_ov),    128'd0);
        chk("t6_rst_ir",    128'(b_ir),    128'd1);
        chk("t6_rst_dout",  128'(b_dout),  128'd0);
        chk("t6_rst_stall", 128'(b_stall), 128'd0);
        b_iv = 1'b1; b_din = W'(32'h21);
        #1;
        chk("t6_rst_lat0", 128'(b_ov), 128'd0);
        tick();
        b_iv = 1'b0;
        chk("t6_rst_lat1", 128'(b_dout), 128'h21);

        // Soft reset mid-stream with a push offered
        b_iv = 1'b1; b_din = W'(32'h22); b_srst = 1'b1;
        tick();
        b_srst = 1'b0; b_iv = 1'b0;
        chk("t6_srst_occ",   128'(b_occ),   128'd0);
        chk("t6_srst_dout",  128'(b_dout),  128'd0);
        chk("t6_srst_stall", 128'(b_stall), 128'd0);
        b_iv = 1'b1; b_din = W'(32'h31);
        tick();
        chk("t6_srst_lat1", 128'(b_dout), 128'h31);

        // Fill DEPTH=3, then a pop reopens in_ready the following cycle
        b_din = W'(32'h32);
        tick();
        b_din = W'(32'h33);
        tick();
        b_iv = 1'b0;
        chk("full_occ", 128'(b_occ), 128'd3);
        chk("full_ir",  128'(b_ir),  128'd0);
        b_or = 1'b1;
        #1;
        chk("full_ir_pop_cycle", 128'(b_ir), 128'd0);
        tick();
        b_or = 1'b0;
        chk("full_ir_after", 128'(b_ir),   128'd1);
        chk("full_occ_after", 128'(b_occ), 128'd2);
        chk("full_head",     128'(b_dout), 128'h32);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
